// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/divider sequencer; stall[STALL_WD] per-stage hold, div_start launch pulse, busy, sticky div_timeout, wait_cnt[6]
module pipe_ctrl #(
  parameter int STALL_WD    = 6,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_load_use,
  input  logic                ex_div_req,
  input  logic                div_done,
  output logic [STALL_WD-1:0] stall,
  output logic                div_start,
  output logic                busy,
  output logic                div_timeout,
  output logic [5:0]          wait_cnt
);
  typedef enum logic [1:0] {IDLE, DIV_WAIT, DIV_DONE} state_t;
  localparam logic [STALL_WD-1:0] STALL_DIV = STALL_WD'(4'b1111);
  localparam logic [STALL_WD-1:0] STALL_LU  = STALL_WD'(3'b111);
  state_t state, next;
  logic   launch, expire;
  assign launch = (state == IDLE) && ex_div_req;
  assign expire = (state == DIV_WAIT) && !div_done && (wait_cnt == 6'(DIV_TIMEOUT - 1));
  assign busy   = state != IDLE;
  always_comb begin
    next      = IDLE;
    div_start = 1'b0;
    stall     = '0;
    case (state)
      IDLE: begin
        next      = ex_div_req ? DIV_WAIT : IDLE;
        div_start = ex_div_req;
        stall     = ex_div_req ? STALL_DIV : id_load_use ? STALL_LU : '0;
      end
      DIV_WAIT: begin
        next  = div_done ? DIV_DONE : expire ? IDLE : DIV_WAIT;
        stall = STALL_DIV;
      end
      default: next = IDLE;
    endcase
    div_start = div_start & rst;
    stall     = rst ? stall : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      div_timeout <= 1'b0;
    end else begin
      state <= next;
      if (launch)
        wait_cnt <= '0;
      else if (state == DIV_WAIT && !div_done && !expire && wait_cnt != 6'd63)
        wait_cnt <= wait_cnt + 6'd1;
      if (expire)
        div_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
  logic       clk = 1'b0;
  logic       rst, id_load_use, ex_div_req, div_done;
  logic [5:0] stall;
  logic       div_start, busy, div_timeout;
  logic [5:0] wait_cnt;
  int         n_cmp = 0, n_bad = 0;
  pipe_ctrl #(.STALL_WD(6), .DIV_TIMEOUT(40)) dut (
    .clk(clk), .rst(rst), .id_load_use(id_load_use), .ex_div_req(ex_div_req),
    .div_done(div_done), .stall(stall), .div_start(div_start), .busy(busy),
    .div_timeout(div_timeout), .wait_cnt(wait_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic ok;
    rst = 1'b0; id_load_use = 1'b1; ex_div_req = 1'b1; div_done = 1'b0;
    #2;
    chk("rst_stall", 32'(stall), 32'h00);
    chk("rst_start", 32'(div_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(wait_cnt), 0);
    chk("rst_tmo", 32'(div_timeout), 0);
    id_load_use = 1'b0; ex_div_req = 1'b0;
    nxt; rst = 1'b1;
    nxt;
    chk("idle_stall", 32'(stall), 32'h00);
    // load-use bubble
    nxt; id_load_use = 1'b1; #1;
    chk("lu_stall", 32'(stall), 32'h07);
    chk("lu_start", 32'(div_start), 0);
    chk("lu_busy", 32'(busy), 0);
    nxt; id_load_use = 1'b0; #1;
    chk("lu_release", 32'(stall), 32'h00);
    chk("lu_busy2", 32'(busy), 0);
    // divide, div_done at cycle 33
    nxt; ex_div_req = 1'b1; #1;
    chk("div_c0_start", 32'(div_start), 1);
    chk("div_c0_stall", 32'(stall), 32'h0f);
    nxt; ex_div_req = 1'b0; #1;
    chk("div_c1_busy", 32'(busy), 1);
    chk("div_c1_cnt", 32'(wait_cnt), 0);
    chk("div_c1_start", 32'(div_start), 0);
    ok = 1'b1;
    for (int c = 2; c <= 32; c++) begin
      nxt;
      id_load_use = (c == 5); ex_div_req = (c == 5); #1;
      ok &= (stall == 6'h0f) && !div_start && busy;
    end
    id_load_use = 1'b0; ex_div_req = 1'b0;
    chk("div_wait_hold", 32'(ok), 1);
    nxt; div_done = 1'b1; #1;
    chk("div_c33_stall", 32'(stall), 32'h0f);
    chk("div_c33_cnt", 32'(wait_cnt), 32);
    nxt; div_done = 1'b0; id_load_use = 1'b1; #1;
    chk("done_stall", 32'(stall), 32'h00);
    chk("done_busy", 32'(busy), 1);
    chk("done_start", 32'(div_start), 0);
    chk("done_cnt", 32'(wait_cnt), 32);
    nxt; id_load_use = 1'b0; div_done = 1'b1; #1;
    chk("c35_idle", 32'(busy), 0);
    nxt; div_done = 1'b0; #1;
    chk("idle_done_ignored", 32'(busy), 0);
    // priority then timeout
    nxt; ex_div_req = 1'b1; id_load_use = 1'b1; #1;
    chk("pri_stall", 32'(stall), 32'h0f);
    chk("pri_start", 32'(div_start), 1);
    nxt; ex_div_req = 1'b0; id_load_use = 1'b0; #1;
    chk("pri_wait", 32'(busy), 1);
    for (int c = 2; c <= 40; c++) nxt;
    chk("tmo_c40_cnt", 32'(wait_cnt), 39);
    chk("tmo_c40_stall", 32'(stall), 32'h0f);
    chk("tmo_c40_flag", 32'(div_timeout), 0);
    nxt;
    chk("tmo_c41_flag", 32'(div_timeout), 1);
    chk("tmo_c41_stall", 32'(stall), 32'h00);
    chk("tmo_c41_busy", 32'(busy), 0);
    chk("tmo_c41_cnt", 32'(wait_cnt), 39);
    // divide still accepted after timeout; reset at cycle 10
    nxt; ex_div_req = 1'b1; #1;
    chk("post_tmo_start", 32'(div_start), 1);
    nxt; ex_div_req = 1'b0;
    for (int c = 2; c <= 10; c++) nxt;
    chk("pre_rst_cnt", 32'(wait_cnt), 9);
    rst = 1'b0; #1;
    chk("arst_stall", 32'(stall), 32'h00);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_tmo", 32'(div_timeout), 0);
    chk("arst_cnt", 32'(wait_cnt), 0);
    nxt; rst = 1'b1; #1;
    chk("rel_start", 32'(div_start), 0);
    chk("rel_busy", 32'(busy), 0);
    nxt;
    chk("rel_busy2", 32'(busy), 0);
    // back-to-back with ex_div_req held
    nxt; ex_div_req = 1'b1; #1;
    chk("b2b_c0_start", 32'(div_start), 1);
    nxt;
    chk("b2b_c1_start", 32'(div_start), 0);
    nxt; div_done = 1'b1; #1;
    chk("b2b_c2_stall", 32'(stall), 32'h0f);
    nxt; div_done = 1'b0; #1;
    chk("b2b_done_start", 32'(div_start), 0);
    chk("b2b_done_stall", 32'(stall), 32'h00);
    chk("b2b_done_busy", 32'(busy), 1);
    nxt;
    chk("b2b_idle_start", 32'(div_start), 1);
    chk("b2b_idle_stall", 32'(stall), 32'h0f);
    nxt; ex_div_req = 1'b0; #1;
    chk("b2b_rewait", 32'(busy), 1);
    chk("b2b_recnt", 32'(wait_cnt), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
